// File: rtl/gpio_mmio_if.sv
// CPU-side memory-mapped bus between the core and the GPIO block.
// The master drives address/data/strobe; the slave returns load data and decode hit.
interface gpio_mmio_if;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic [31:0] ReadData;
   logic        hit;

   modport master (
      output DataAdr,
      output WriteData,
      output MemWrite,
      input  ReadData,
      input  hit
   );

   modport slave (
      input  DataAdr,
      input  WriteData,
      input  MemWrite,
      output ReadData,
      output hit
   );
endinterface

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: debounced switch inputs with edge capture and interrupt,
// plus an LED output register with set/clear/toggle aliases.
module gpio_mmio #(
   parameter int unsigned N_IN      = 10,
   parameter int unsigned N_OUT     = 10,
   parameter logic [31:0] BASE      = 32'hC000_0000,
   parameter int unsigned DEBOUNCE  = 4,
   parameter int unsigned EDGE_MODE = 0
) (
   input  logic             clk,
   input  logic             reset,
   gpio_mmio_if.slave       bus,
   input  logic [N_IN-1:0]  switches,
   output logic [N_OUT-1:0] leds,
   output logic             irq
);

   localparam int unsigned   CW       = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   localparam logic [2:0] OFF_IN     = 3'd0;
   localparam logic [2:0] OFF_OUT    = 3'd1;
   localparam logic [2:0] OFF_SET    = 3'd2;
   localparam logic [2:0] OFF_CLR    = 3'd3;
   localparam logic [2:0] OFF_TGL    = 3'd4;
   localparam logic [2:0] OFF_EDGE   = 3'd5;
   localparam logic [2:0] OFF_IRQ_EN = 3'd6;

   logic [2:0]       off;
   logic             wr;
   logic [N_OUT-1:0] wd_out;
   logic [N_IN-1:0]  wd_in;

   logic [N_IN-1:0]  sync1_q, sync2_q;
   logic [N_IN-1:0]  in_q, in_d;
   logic [CW-1:0]    cnt_q [N_IN];
   logic [CW-1:0]    cnt_d [N_IN];
   logic [N_IN-1:0]  diff, done;
   logic [N_IN-1:0]  edge_q, edge_d, edge_set, w1c;
   logic [N_IN-1:0]  irq_en_q, irq_en_d;
   logic [N_OUT-1:0] out_q, out_d;

   assign off     = bus.DataAdr[4:2];
   assign bus.hit = (bus.DataAdr[31:5] == BASE[31:5]);
   assign wr      = bus.MemWrite & bus.hit;
   assign wd_out  = bus.WriteData[N_OUT-1:0];
   assign wd_in   = bus.WriteData[N_IN-1:0];

   // Counter only runs while the synchronised value disagrees with IN;
   // reaching DEBOUNCE accepts the new value and restarts from zero.
   generate
      for (genvar gi = 0; gi < N_IN; gi++) begin : g_debounce
         assign diff[gi]  = sync2_q[gi] ^ in_q[gi];
         assign done[gi]  = diff[gi] && (cnt_q[gi] == CNT_LAST);
         assign in_d[gi]  = done[gi] ? sync2_q[gi] : in_q[gi];
         assign cnt_d[gi] = (diff[gi] && !done[gi]) ? cnt_q[gi] + 1'b1 : '0;
      end
   endgenerate

   always_comb begin
      case (EDGE_MODE)
         0:       edge_set = in_d & ~in_q;
         1:       edge_set = ~in_d & in_q;
         default: edge_set = in_d ^ in_q;
      endcase
   end

   // A new edge overrides a simultaneous write-one-to-clear on the same bit.
   assign w1c    = (wr && off == OFF_EDGE) ? wd_in : '0;
   assign edge_d = (edge_q & ~w1c) | edge_set;

   always_comb begin
      out_d    = out_q;
      irq_en_d = irq_en_q;
      if (wr) begin
         case (off)
            OFF_OUT:    out_d    = wd_out;
            OFF_SET:    out_d    = out_q | wd_out;
            OFF_CLR:    out_d    = out_q & ~wd_out;
            OFF_TGL:    out_d    = out_q ^ wd_out;
            OFF_IRQ_EN: irq_en_d = wd_in;
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         in_q     <= '0;
         cnt_q    <= '{default: '0};
         out_q    <= '0;
         edge_q   <= '0;
         irq_en_q <= '0;
      end else begin
         sync1_q  <= switches;
         sync2_q  <= sync1_q;
         in_q     <= in_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         edge_q   <= edge_d;
         irq_en_q <= irq_en_d;
      end
   end

   always_comb begin
      case (off)
         OFF_IN:     bus.ReadData = 32'(in_q);
         OFF_OUT:    bus.ReadData = 32'(out_q);
         OFF_EDGE:   bus.ReadData = 32'(edge_q);
         OFF_IRQ_EN: bus.ReadData = 32'(irq_en_q);
         default:    bus.ReadData = 32'd0;
      endcase
   end

   assign leds = out_q;
   assign irq  = |(edge_q & irq_en_q);

endmodule
